// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC register and single-outstanding instruction-port engine.
// Latches pc_next from the next-PC mux, issues one word-aligned request at a time, holds the
// returned word for the F/D boundary and feeds pcF + 4 back to the mux.
// An exception redirect that arrives while a request is in flight marks that request stale,
// so its returning data is dropped instead of being paired with the new PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a misaligned pcF is not
// fetched; the unit presents a nop with adelF=1 instead. When undefined, pcF[1:0] is ignored.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_next,
    input  logic        stallF,
    input  logic        flushF,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instrF,
    output logic        instr_validF,
    output logic        adelF,
    output logic        i_stall
);

    localparam int unsigned XLEN = 32;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // REQ: request presented (or about to be), WAIT: accepted, data pending,
    // HOLD: instruction available, DISCARD: accepted request whose data is stale.
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pcF;
    logic [XLEN-1:0]   r_instrF;
    logic              r_instr_valid;
    logic              r_inst_req;
    logic              r_adelF;

    logic              w_next_aligned;
    logic              w_cur_aligned;
    logic              w_accept;

    // Alignment qualifiers; both collapse to 1 when the check is compiled out.
    assign w_next_aligned = !ALIGN_CHK || (pc_next[1:0] == 2'b00);
    assign w_cur_aligned  = !ALIGN_CHK || (r_pcF[1:0] == 2'b00);

    // A request is accepted only while it is actually being presented.
    assign w_accept = r_inst_req && inst_addr_ok;

    // Fetch sequencer: state, PC, fetched word and registered request/status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_REQ;
            r_pcF         <= RESET_PC;
            r_instrF      <= '0;
            r_instr_valid <= 1'b0;
            r_inst_req    <= 1'b0;
            r_adelF       <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (flushF) begin
                        r_pcF         <= pc_next;
                        r_instr_valid <= 1'b0;
                        r_adelF       <= 1'b0;
                        if (w_accept) begin
                            // Old address already taken by memory: its data must be dropped.
                            r_state    <= ST_DISCARD;
                            r_inst_req <= 1'b0;
                        end else begin
                            r_state    <= ST_REQ;
                            r_inst_req <= w_next_aligned;
                        end
                    end else if (r_inst_req) begin
                        if (inst_addr_ok) begin
                            r_state    <= ST_WAIT;
                            r_inst_req <= 1'b0;
                        end
                    end else if (w_cur_aligned) begin
                        // Idle REQ (just out of reset): start presenting the request.
                        r_inst_req <= 1'b1;
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    else begin
                        // Misaligned PC: skip the memory access and hand over a faulting nop.
                        r_state       <= ST_HOLD;
                        r_instrF      <= '0;
                        r_instr_valid <= 1'b1;
                        r_adelF       <= 1'b1;
                    end
`endif
                end

                ST_WAIT: begin
                    if (flushF) begin
                        r_pcF         <= pc_next;
                        r_instr_valid <= 1'b0;
                        r_adelF       <= 1'b0;
                        if (inst_data_ok) begin
                            // Data arrives with the redirect: drop it, refetch at once.
                            r_state    <= ST_REQ;
                            r_inst_req <= w_next_aligned;
                        end else begin
                            r_state    <= ST_DISCARD;
                            r_inst_req <= 1'b0;
                        end
                    end else if (inst_data_ok) begin
                        r_state       <= ST_HOLD;
                        r_instrF      <= inst_rdata;
                        r_instr_valid <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (flushF || !stallF) begin
                        r_state       <= ST_REQ;
                        r_pcF         <= pc_next;
                        r_instr_valid <= 1'b0;
                        r_adelF       <= 1'b0;
                        r_inst_req    <= w_next_aligned;
                    end
                end

                ST_DISCARD: begin
                    if (flushF) begin
                        r_pcF         <= pc_next;
                        r_instr_valid <= 1'b0;
                        r_adelF       <= 1'b0;
                    end
                    if (inst_data_ok) begin
                        // Stale word returned; the outstanding slot is free again.
                        r_state    <= ST_REQ;
                        r_inst_req <= flushF ? w_next_aligned : w_cur_aligned;
                    end
                end

                default: begin
                    r_state    <= ST_REQ;
                    r_inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req     = r_inst_req;
    assign inst_addr    = {r_pcF[XLEN-1:2], 2'b00};
    assign pcF          = r_pcF;
    assign pc_plus4F    = r_pcF + XLEN'(4);
    assign instrF       = r_instrF;
    assign instr_validF = r_instr_valid;
    assign adelF        = r_adelF;
    assign i_stall      = (r_state != ST_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then randomized
// memory timing, stalls, redirects and resets checked every cycle against a transaction model.

module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [31:0] pc_next;
    logic        stallF;
    logic        flushF;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic [31:0] instrF;
    logic        instr_validF;
    logic        adelF;
    logic        i_stall;

    int n_chk = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_next      (pc_next),
        .stallF       (stallF),
        .flushF       (flushF),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .pcF          (pcF),
        .pc_plus4F    (pc_plus4F),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .adelF        (adelF),
        .i_stall      (i_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit aligned(input logic [31:0] pc);
        return !ALIGN_CHK || (pc[1:0] == 2'b00);
    endfunction

    // Transaction-level model: held instruction, accepted-but-unanswered request,
    // whether that request is stale, and whether a request is being presented.
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_adel  = 1'b0;
    bit          m_pend  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_req   = 1'b0;
    bit          m_acc;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pc = RST_PC; m_instr = 32'h0; m_valid = 0; m_adel = 0;
            m_pend = 0; m_stale = 0; m_req = 0;
        end else begin
            m_acc = m_req && inst_addr_ok;
            if (flushF) begin
                m_pc    = pc_next;
                m_valid = 0;
                m_adel  = 0;
                m_pend  = m_acc || (m_pend && !inst_data_ok);
                m_stale = m_pend;
                m_req   = !m_pend && aligned(pc_next);
            end else if (m_valid) begin
                if (!stallF) begin
                    m_pc = pc_next; m_valid = 0; m_adel = 0; m_req = aligned(pc_next);
                end
            end else if (m_pend) begin
                if (inst_data_ok) begin
                    m_pend = 0;
                    if (m_stale) begin
                        m_stale = 0;
                        m_req   = aligned(m_pc);
                    end else begin
                        m_instr = inst_rdata;
                        m_valid = 1;
                    end
                end
            end else if (m_req) begin
                if (inst_addr_ok) begin
                    m_pend = 1; m_req = 0;
                end
            end else if (aligned(m_pc)) begin
                m_req = 1;
            end else begin
                m_valid = 1; m_instr = 32'h0; m_adel = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("m_i_stall", 32'(i_stall), 32'(!m_valid));
        chk("m_inst_req", 32'(inst_req), 32'(m_req));
        if (m_req) chk("m_inst_addr", inst_addr, {m_pc[31:2], 2'b00});
        chk("m_pcF", pcF, m_pc);
        chk("m_pc_plus4F", pc_plus4F, m_pc + 32'd4);
        chk("m_instr_validF", 32'(instr_validF), 32'(m_valid));
        chk("m_instrF", instrF, m_instr);
        chk("m_adelF", 32'(adelF), 32'(m_adel));
    end

    bit          acc_drv;
    bit          dat_drv;
    bit          mem_pend;
    bit          rst_pend;
    int          cnt;
    logic [31:0] tmp;
    int          r;

    initial begin
        resetn = 1'b0; pc_next = 32'hBFC0_0004; stallF = 0; flushF = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_i_stall", 32'(i_stall), 32'd1);
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_pcF", pcF, 32'hBFC0_0000);
        chk("rst_valid", 32'(instr_validF), 32'd0);
        chk("rst_instrF", instrF, 32'h0);
        chk("rst_adelF", 32'(adelF), 32'd0);
        resetn = 1'b1;

        // Basic fetch from reset vector.
        @(negedge clk);
        chk("t1_req", 32'(inst_req), 32'd1);
        chk("t1_addr", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0;
        chk("t1_wait_req", 32'(inst_req), 32'd0);
        inst_data_ok = 1; inst_rdata = 32'h2402_0001;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t1_valid", 32'(instr_validF), 32'd1);
        chk("t1_instr", instrF, 32'h2402_0001);
        chk("t1_i_stall", 32'(i_stall), 32'd0);
        chk("t1_plus4", pc_plus4F, 32'hBFC0_0004);
        pc_next = 32'hBFC0_0004;
        @(negedge clk);
        chk("t1_pc_adv", pcF, 32'hBFC0_0004);

        // Delayed addr_ok: request stable for four cycles; then stall in HOLD.
        for (int k = 0; k < 3; k++) begin
            chk("t2_req_stable", 32'(inst_req), 32'd1);
            chk("t2_addr_stable", inst_addr, 32'hBFC0_0004);
            @(negedge clk);
        end
        chk("t2_req_stable", 32'(inst_req), 32'd1);
        chk("t2_addr_stable", inst_addr, 32'hBFC0_0004);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h8FBF_0010;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t2_valid", 32'(instr_validF), 32'd1);
        stallF = 1; pc_next = 32'hBFC0_0008;
        @(negedge clk);
        chk("t2_stall_pc", pcF, 32'hBFC0_0004);
        chk("t2_stall_instr", instrF, 32'h8FBF_0010);
        chk("t2_stall_i_stall", 32'(i_stall), 32'd0);
        @(negedge clk);
        chk("t2_stall_pc2", pcF, 32'hBFC0_0004);
        stallF = 0;
        @(negedge clk);
        chk("t2_adv_pc", pcF, 32'hBFC0_0008);
        inst_addr_ok = 1;

        // Redirect while waiting; stale data arrives two cycles later.
        @(negedge clk);
        inst_addr_ok = 0; flushF = 1; pc_next = 32'hBFC0_0380;
        @(negedge clk);
        flushF = 0;
        chk("t3_pc", pcF, 32'hBFC0_0380);
        chk("t3_valid", 32'(instr_validF), 32'd0);
        chk("t3_req", 32'(inst_req), 32'd0);
        @(negedge clk);
        inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t3_req_new", 32'(inst_req), 32'd1);
        chk("t3_addr_new", inst_addr, 32'hBFC0_0380);
        chk("t3_valid_still0", 32'(instr_validF), 32'd0);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h1111_2222;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t3_instr", instrF, 32'h1111_2222);
        pc_next = 32'hBFC0_0384;

        // Redirect coinciding with data_ok.
        @(negedge clk);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; flushF = 1; inst_data_ok = 1; inst_rdata = 32'hBAD0_BAD0;
        pc_next = 32'hBFC0_0500;
        @(negedge clk);
        flushF = 0; inst_data_ok = 0;
        chk("t4_req", 32'(inst_req), 32'd1);
        chk("t4_addr", inst_addr, 32'hBFC0_0500);
        chk("t4_valid", 32'(instr_validF), 32'd0);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3C1D_0001;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t4_instr", instrF, 32'h3C1D_0001);
        pc_next = 32'hFFFF_FFFC;

        // pc_plus4F wraps.
        @(negedge clk);
        chk("t5_pc", pcF, 32'hFFFF_FFFC);
        chk("t5_plus4", pc_plus4F, 32'h0000_0000);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h1234_5678;
        @(negedge clk);
        inst_data_ok = 0;
        pc_next = 32'hBFC0_0002;

        // Misaligned PC.
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_no_req", 32'(inst_req), 32'd0);
        @(negedge clk);
        chk("t6_adel", 32'(adelF), 32'd1);
        chk("t6_nop", instrF, 32'h0);
        chk("t6_valid", 32'(instr_validF), 32'd1);
        chk("t6_no_req2", 32'(inst_req), 32'd0);
        pc_next = 32'hBFC0_0010;
        @(negedge clk);
        chk("t6_adel_clr", 32'(adelF), 32'd0);
`else
        chk("t6_req", 32'(inst_req), 32'd1);
        chk("t6_addr", inst_addr, 32'hBFC0_0000);
        chk("t6_adel", 32'(adelF), 32'd0);
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h2484_0004;
        @(negedge clk);
        inst_data_ok = 0;
        chk("t6_instr", instrF, 32'h2484_0004);
        chk("t6_adel2", 32'(adelF), 32'd0);
        pc_next = 32'hBFC0_0010;
        @(negedge clk);
`endif
        chk("t6_next_pc", pcF, 32'hBFC0_0010);

        // Asynchronous reset while waiting for data.
        inst_addr_ok = 1;
        @(negedge clk);
        inst_addr_ok = 0;
        chk("t7_wait_req", 32'(inst_req), 32'd0);
        #1 resetn = 1'b0;
        #1;
        chk("t7_pc", pcF, RST_PC);
        chk("t7_req", 32'(inst_req), 32'd0);
        chk("t7_i_stall", 32'(i_stall), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic.
        acc_drv = 0; dat_drv = 0; mem_pend = 0; rst_pend = 0; cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst_pend) begin
                resetn = 1'b1; rst_pend = 0; mem_pend = 0;
            end else begin
                if (acc_drv) begin mem_pend = 1; cnt = $urandom_range(0, 3); end
                if (dat_drv) mem_pend = 0;
            end
            acc_drv = 0; dat_drv = 0;
            flushF = ($urandom_range(0, 9) == 0);
            stallF = ($urandom_range(0, 3) == 0);
            tmp = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0)      pc_next = 32'hFFFF_FFFC;
            else if (r < 3)  pc_next = {tmp[31:2], 2'(r)};
            else             pc_next = {tmp[31:2], 2'b00};
            if (inst_req) begin
                inst_addr_ok = !mem_pend && ($urandom_range(0, 1) == 1);
                acc_drv = inst_addr_ok;
            end else begin
                inst_addr_ok = ($urandom_range(0, 3) == 0);
            end
            if (mem_pend) begin
                if (cnt == 0) begin
                    inst_data_ok = 1; dat_drv = 1;
                end else begin
                    cnt--; inst_data_ok = 0;
                end
            end else begin
                inst_data_ok = ($urandom_range(0, 7) == 0);
            end
            inst_rdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #1 resetn = 1'b0;
                rst_pend = 1;
            end
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
